// File: rtl/bm_pkg.sv
// Shared definitions for the grid actor controller: move direction codes,
// arena cell indexing and player spawn corners.
package bm_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_e;

    function automatic int cell_idx(input int x, input int y, input int w);
        return y * w + x;
    endfunction

    // Corners: p0 top-left, p1 bottom-right, p2 top-right, p3 bottom-left.
    function automatic int spawn_x(input int p, input int w);
        return (p == 1 || p == 2) ? w - 1 : 0;
    endfunction

    function automatic int spawn_y(input int p, input int h);
        return (p == 1 || p == 3) ? h - 1 : 0;
    endfunction

endpackage

// File: rtl/bomb_fuse_slot.sv
// One bomb-table entry: position, owner and a fuse that counts down on tick.
// The slot stays live and expired until cleared by the explosion handshake.
module bomb_fuse_slot #(
    parameter int XW         = 4,
    parameter int YW         = 4,
    parameter int PW         = 1,
    parameter int FUSE_TICKS = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          load,
    input  logic [XW-1:0] load_x,
    input  logic [YW-1:0] load_y,
    input  logic [PW-1:0] load_owner,
    input  logic          clear,
    output logic          valid,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [PW-1:0] owner,
    output logic          expired
);

    localparam int FW = $clog2(FUSE_TICKS + 1);

    logic [FW-1:0] fuse;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            x     <= '0;
            y     <= '0;
            owner <= '0;
            fuse  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            x     <= load_x;
            y     <= load_y;
            owner <= load_owner;
            fuse  <= FW'(FUSE_TICKS);
        end else if (clear) begin
            valid <= 1'b0;
        end else if (tick && valid && fuse != '0) begin
            fuse <= fuse - 1'b1;
        end
    end

    assign expired = valid && (fuse == '0);

endmodule

// File: rtl/grid_actor_ctrl.sv
// Player movement and bomb controller: round-robin move/placement arbitration
// against walls and bombs, fuse table, and a valid/ready expiry port.
module grid_actor_ctrl
    import bm_pkg::*;
#(
    parameter int GRID_W           = 10,
    parameter int GRID_H           = 10,
    parameter int NUM_PLAYERS      = 2,
    parameter int MAX_BOMBS        = 8,
    parameter int BOMBS_PER_PLAYER = 2,
    parameter int FUSE_TICKS       = 3,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H),
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick,
    input  logic [3*NUM_PLAYERS-1:0]    move_dir,
    input  logic [NUM_PLAYERS-1:0]      bomb_req,
    input  logic [NUM_PLAYERS-1:0]      alive,
    input  logic [GRID_W*GRID_H-1:0]    wall_map,
    output logic [XW*NUM_PLAYERS-1:0]   player_x,
    output logic [YW*NUM_PLAYERS-1:0]   player_y,
    output logic [GRID_W*GRID_H-1:0]    bomb_map,
    output logic                        expl_valid,
    input  logic                        expl_ready,
    output logic [XW-1:0]               expl_x,
    output logic [YW-1:0]               expl_y,
    output logic [PW-1:0]               expl_owner
);

    localparam int CELLS = GRID_W * GRID_H;
    localparam int CIW   = $clog2(CELLS);
    localparam int SW    = (MAX_BOMBS > 1) ? $clog2(MAX_BOMBS) : 1;
    localparam int CW    = $clog2(BOMBS_PER_PLAYER + 1);

    function automatic logic [CIW-1:0] cell_of(input int x, input int y);
        return CIW'(cell_idx(x, y, GRID_W));
    endfunction

    logic [XW-1:0]        px_q [NUM_PLAYERS];
    logic [YW-1:0]        py_q [NUM_PLAYERS];
    logic [XW-1:0]        px_n [NUM_PLAYERS];
    logic [YW-1:0]        py_n [NUM_PLAYERS];
    logic [CW-1:0]        live_cnt [NUM_PLAYERS];
    logic [PW-1:0]        rr_ptr;
    logic [NUM_PLAYERS-1:0] placed, freed;

    logic [MAX_BOMBS-1:0] slot_valid, slot_expired, slot_load, slot_clear;
    logic [XW-1:0]        slot_x [MAX_BOMBS];
    logic [YW-1:0]        slot_y [MAX_BOMBS];
    logic [PW-1:0]        slot_owner [MAX_BOMBS];
    logic [XW-1:0]        ld_x [MAX_BOMBS];
    logic [YW-1:0]        ld_y [MAX_BOMBS];
    logic [PW-1:0]        ld_owner [MAX_BOMBS];
    logic [CELLS-1:0]     cell_busy;

    logic                 low_found, lock_q, expl_fire;
    logic [SW-1:0]        low_idx, lock_idx_q, cur_idx;

    for (genvar g = 0; g < MAX_BOMBS; g++) begin : g_slot
        bomb_fuse_slot #(
            .XW(XW), .YW(YW), .PW(PW), .FUSE_TICKS(FUSE_TICKS)
        ) u_slot (
            .clk(clk), .rst(rst), .tick(tick),
            .load(slot_load[g]), .load_x(ld_x[g]), .load_y(ld_y[g]), .load_owner(ld_owner[g]),
            .clear(slot_clear[g]),
            .valid(slot_valid[g]), .x(slot_x[g]), .y(slot_y[g]), .owner(slot_owner[g]),
            .expired(slot_expired[g])
        );
    end

    always_comb begin
        bomb_map = '0;
        for (int unsigned s = 0; s < MAX_BOMBS; s++)
            if (slot_valid[SW'(s)])
                bomb_map[cell_of(int'(slot_x[SW'(s)]), int'(slot_y[SW'(s)]))] = 1'b1;
    end

    // Placement runs first so bombs dropped this tick already block moves.
    always_comb begin
        logic [PW-1:0]        p;
        logic [CIW-1:0]       c;
        logic [SW-1:0]        fs;
        logic                 found;
        logic                 ok;
        int                   tx;
        int                   ty;
        logic [MAX_BOMBS-1:0] used;

        p = '0; c = '0; fs = '0; found = 1'b0; ok = 1'b0; tx = 0; ty = 0;
        used      = slot_valid;
        cell_busy = bomb_map;
        slot_load = '0;
        placed    = '0;
        for (int unsigned s = 0; s < MAX_BOMBS; s++) begin
            ld_x[SW'(s)]     = '0;
            ld_y[SW'(s)]     = '0;
            ld_owner[SW'(s)] = '0;
        end
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            px_n[PW'(i)] = px_q[PW'(i)];
            py_n[PW'(i)] = py_q[PW'(i)];
        end

        if (tick) begin
            for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
                p     = PW'((int'(rr_ptr) + int'(k)) % NUM_PLAYERS);
                c     = cell_of(int'(px_q[p]), int'(py_q[p]));
                found = 1'b0;
                fs    = '0;
                for (int unsigned s = 0; s < MAX_BOMBS; s++)
                    if (!found && !used[SW'(s)]) begin
                        found = 1'b1;
                        fs    = SW'(s);
                    end
                if (found && alive[p] && bomb_req[p] && !cell_busy[c] &&
                    int'(live_cnt[p]) < BOMBS_PER_PLAYER) begin
                    used[fs]      = 1'b1;
                    slot_load[fs] = 1'b1;
                    ld_x[fs]      = px_q[p];
                    ld_y[fs]      = py_q[p];
                    ld_owner[fs]  = p;
                    cell_busy[c]  = 1'b1;
                    placed[p]     = 1'b1;
                end
            end

            for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
                p  = PW'((int'(rr_ptr) + int'(k)) % NUM_PLAYERS);
                tx = int'(px_q[p]);
                ty = int'(py_q[p]);
                ok = alive[p];
                case (move_dir[3*p +: 3])
                    DIR_UP:    if (ty == 0) ok = 1'b0; else ty = ty - 1;
                    DIR_DOWN:  if (ty == GRID_H - 1) ok = 1'b0; else ty = ty + 1;
                    DIR_LEFT:  if (tx == 0) ok = 1'b0; else tx = tx - 1;
                    DIR_RIGHT: if (tx == GRID_W - 1) ok = 1'b0; else tx = tx + 1;
                    default:   ok = 1'b0;
                endcase
                c = cell_of(tx, ty);
                if (wall_map[c] || cell_busy[c])
                    ok = 1'b0;
                for (int unsigned q = 0; q < NUM_PLAYERS; q++)
                    if (PW'(q) != p && int'(px_n[PW'(q)]) == tx && int'(py_n[PW'(q)]) == ty)
                        ok = 1'b0;
                if (ok) begin
                    px_n[p] = XW'(tx);
                    py_n[p] = YW'(ty);
                end
            end
        end
    end

    always_comb begin
        low_found = 1'b0;
        low_idx   = '0;
        for (int unsigned s = 0; s < MAX_BOMBS; s++)
            if (!low_found && slot_expired[SW'(s)]) begin
                low_found = 1'b1;
                low_idx   = SW'(s);
            end
    end

    // A stalled presentation is locked so a lower slot expiring later cannot displace it.
    assign cur_idx    = lock_q ? lock_idx_q : low_idx;
    assign expl_valid = lock_q | low_found;
    assign expl_x     = slot_x[cur_idx];
    assign expl_y     = slot_y[cur_idx];
    assign expl_owner = slot_owner[cur_idx];
    assign expl_fire  = expl_valid & expl_ready;

    always_comb begin
        slot_clear = '0;
        freed      = '0;
        if (expl_fire) begin
            slot_clear[cur_idx]         = 1'b1;
            freed[slot_owner[cur_idx]]  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                px_q[PW'(i)]     <= XW'(spawn_x(int'(i), GRID_W));
                py_q[PW'(i)]     <= YW'(spawn_y(int'(i), GRID_H));
                live_cnt[PW'(i)] <= '0;
            end
        end else begin
            lock_q     <= expl_valid & ~expl_ready;
            lock_idx_q <= cur_idx;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                px_q[PW'(i)]     <= px_n[PW'(i)];
                py_q[PW'(i)]     <= py_n[PW'(i)];
                live_cnt[PW'(i)] <= live_cnt[PW'(i)] + CW'(placed[PW'(i)]) - CW'(freed[PW'(i)]);
            end
            if (tick)
                rr_ptr <= (int'(rr_ptr) == NUM_PLAYERS - 1) ? '0 : rr_ptr + 1'b1;
        end
    end

    always_comb begin
        player_x = '0;
        player_y = '0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            player_x[i*XW +: XW] = px_q[PW'(i)];
            player_y[i*YW +: YW] = py_q[PW'(i)];
        end
    end

endmodule
